// File: rtl/pri_enc_arb.sv
// Registered N-way priority encoder / arbiter with a valid/ack grant hold.
// The winner is chosen by fixed priority or round-robin on the IDLE->GRANT edge.
module pri_enc_arb #(
   parameter int N = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req,
   input  logic                   mode,
   input  logic                   ack,
   output logic                   valid,
   output logic [$clog2(N)-1:0]   idx,
   output logic [N-1:0]           grant
);

   localparam int IDX_W = $clog2(N);

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   state_e             state_q, state_d;
   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               mode_q, mode_d;

   logic [IDX_W-1:0]   fx_win;
   logic [IDX_W-1:0]   rr_win;
   logic [IDX_W-1:0]   win;
   logic [N-1:0]       one_hot;

   // Highest set index wins; later iterations override earlier ones.
   always_comb begin
      fx_win = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            fx_win = IDX_W'(i);
         end
      end
   end

   // Walk offsets downward so the smallest offset from ptr wins.
   always_comb begin
      int j;
      rr_win = '0;
      j      = 0;
      for (int off = N - 1; off >= 0; off--) begin
         j = int'(ptr_q) + off;
         if (j >= N) begin
            j = j - N;
         end
         if (req[j]) begin
            rr_win = IDX_W'(j);
         end
      end
   end

   always_comb begin
      win     = mode ? rr_win : fx_win;
      one_hot = {{(N-1){1'b0}}, 1'b1} << win;
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            grant_d = '0;
            if (|req) begin
               valid_d = 1'b1;
               idx_d   = win;
               grant_d = one_hot;
               mode_d  = mode;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (ack) begin
               valid_d = 1'b0;
               grant_d = '0;
               state_d = IDLE;
               if (mode_q) begin
                  ptr_d = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         idx_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         mode_q  <= mode_d;
      end
   end

   assign valid = valid_q;
   assign idx   = idx_q;
   assign grant = grant_q;

endmodule

// File: tb/tb_pri_enc_arb.sv
// Directed bench for pri_enc_arb (N=8): hand-computed vectors checked
// with immediate assertions after each clock edge.
module tb_pri_enc_arb;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       mode;
   logic       ack;
   logic       valid;
   logic [2:0] idx;
   logic [7:0] grant;

   int nvec;
   int nerr;

   pri_enc_arb #(.N(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .mode  (mode),
      .ack   (ack),
      .valid (valid),
      .idx   (idx),
      .grant (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic ev,
                      input logic [2:0] ei, input logic [7:0] eg);
      nvec++;
      assert (valid === ev)
      else begin
         nerr++;
         $error("FAIL %s valid: got %b want %b", tag, valid, ev);
      end
      assert (idx === ei)
      else begin
         nerr++;
         $error("FAIL %s idx: got %0d want %0d", tag, idx, ei);
      end
      assert (grant === eg)
      else begin
         nerr++;
         $error("FAIL %s grant: got %b want %b", tag, grant, eg);
      end
   endtask

   initial begin
      logic [2:0] e;
      nvec = 0;
      nerr = 0;
      rst  = 1'b1;
      req  = 8'h00;
      mode = 1'b0;
      ack  = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      chk("reset", 1'b0, 3'd0, 8'h00);

      // 1: fixed priority, held 5 cycles, ack, bubble, re-grant
      req = 8'b1010_1000;
      cyc();
      chk("fx_grant", 1'b1, 3'd7, 8'h80);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("fx_hold", 1'b1, 3'd7, 8'h80);
      end
      ack = 1'b1;
      cyc();
      chk("fx_ack", 1'b0, 3'd7, 8'h00);
      ack = 1'b0;
      cyc();
      chk("fx_regrant", 1'b1, 3'd7, 8'h80);

      // 2: low edge, then empty request
      req = 8'h01;
      ack = 1'b1;
      cyc();
      chk("lo_ack", 1'b0, 3'd7, 8'h00);
      ack = 1'b0;
      cyc();
      chk("lo_grant", 1'b1, 3'd0, 8'h01);
      req = 8'h00;
      ack = 1'b1;
      cyc();
      chk("lo_release", 1'b0, 3'd0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("empty_idle", 1'b0, 3'd0, 8'h00);
      end
      ack = 1'b0;
      cyc();
      chk("empty_idle2", 1'b0, 3'd0, 8'h00);

      // 3: round-robin fairness, ptr starts at 0
      mode = 1'b1;
      req  = 8'hFF;
      cyc();
      for (int k = 0; k < 10; k++) begin
         e = 3'(k % 8);
         chk("rr_grant", 1'b1, e, 8'h01 << e);
         ack = 1'b1;
         cyc();
         chk("rr_bubble", 1'b0, e, 8'h00);
         ack = 1'b0;
         if (k < 9) begin
            cyc();
         end
      end
      req = 8'h00;
      cyc();
      chk("rr_drain", 1'b0, 3'd1, 8'h00);

      // 4: round-robin wrap from reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst2", 1'b0, 3'd0, 8'h00);
      req = 8'b0100_1000;
      cyc();
      chk("wrap_a", 1'b1, 3'd3, 8'h08);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      cyc();
      chk("wrap_b", 1'b1, 3'd6, 8'h40);
      // mode drop during grant must not block the ptr update
      mode = 1'b0;
      ack  = 1'b1;
      cyc();
      chk("wrap_b_ack", 1'b0, 3'd6, 8'h00);
      mode = 1'b1;
      ack  = 1'b0;
      cyc();
      chk("wrap_c", 1'b1, 3'd3, 8'h08);
      ack = 1'b1;
      cyc();
      ack  = 1'b0;
      mode = 1'b0;
      cyc();
      chk("fx_after_rr", 1'b1, 3'd6, 8'h40);

      // 5: hold under req and mode change
      req  = 8'h01;
      mode = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("hold", 1'b1, 3'd6, 8'h40);
      end
      mode = 1'b0;
      ack  = 1'b1;
      cyc();
      chk("hold_ack", 1'b0, 3'd6, 8'h00);
      ack = 1'b0;
      cyc();
      chk("hold_next", 1'b1, 3'd0, 8'h01);
      ack = 1'b1;
      cyc();
      // ptr still 4 after fixed grants: RR picks 6, not 3
      ack  = 1'b0;
      mode = 1'b1;
      req  = 8'b0100_1000;
      cyc();
      chk("ptr_kept", 1'b1, 3'd6, 8'h40);
      ack = 1'b1;
      cyc();
      ack = 1'b0;

      // 6: reach ptr=5, then reset mid-grant
      req = 8'h10;
      cyc();
      chk("ptr5_a", 1'b1, 3'd4, 8'h10);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      req = 8'hFF;
      cyc();
      chk("ptr5_b", 1'b1, 3'd5, 8'h20);
      rst = 1'b1;
      cyc();
      chk("rst_mid", 1'b0, 3'd0, 8'h00);
      rst = 1'b0;
      cyc();
      chk("rst_ptr", 1'b1, 3'd0, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
